// File: rtl/linked_list_fifo_pop_scheduler_pkg.sv
// Shared helpers for the linked-list FIFO pop scheduler: index-width
// derivation and the per-queue count field position inside fifo_count.
package llf_pkg;

  localparam int unsigned DEF_WIDTH      = 64;
  localparam int unsigned DEF_FIFOS      = 4;
  localparam int unsigned DEF_LOG2_DEPTH = 11;
  localparam int unsigned DEF_BURST      = 4;

  // Number of bits needed to hold max_val (at least 1).
  function automatic int unsigned idx_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // LSB of queue idx's occupancy field in the packed fifo_count bus.
  function automatic int count_lsb(input int idx, input int field_w);
    return idx * field_w;
  endfunction

endpackage

// File: rtl/linked_list_fifo_pop_scheduler_rr_pick.sv
// Rotate-priority picker: returns the first requesting index scanning
// ptr+1, ptr+2, ... modulo N, with ptr itself considered last.
//  req     in  N   request per index
//  ptr     in  IW  current priority pointer
//  gnt_idx out IW  chosen index (0 when none)
//  gnt_vld out 1   any request present
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = IW'((32'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/linked_list_fifo_pop_scheduler.sv
// Drains a shared linked-list FIFO bank onto one valid/ready stream using
// burst-limited round robin; a 2-entry buffer hides the RAM read latency.
//  clk, rst              clock / async active-low reset
//  enable                per-queue service mask
//  fifo_count            packed per-queue occupancy
//  fifo_pop, fifo_sel    pop strobe and queue index to the FIFO (combinational)
//  fifo_q                read data, valid the cycle after fifo_pop
//  out_valid/ready/data  output stream, out_fifo = source queue of head
//  busy                  buffered entry or read in flight
module linked_list_fifo_pop_scheduler
  import llf_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFOS      = DEF_FIFOS,
  parameter int unsigned LOG2_FIFOS = idx_width(FIFOS - 1),
  parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int unsigned BURST      = DEF_BURST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FIFOS-1:0]            enable,
  input  logic [LOG2_DEPTH*FIFOS-1:0] fifo_count,
  output logic                        fifo_pop,
  output logic [LOG2_FIFOS-1:0]       fifo_sel,
  input  logic [WIDTH-1:0]            fifo_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [LOG2_FIFOS-1:0]       out_fifo,
  output logic                        busy
);

  localparam int unsigned CW = idx_width(BURST);

  logic [FIFOS-1:0]      elig;
  logic [LOG2_FIFOS-1:0] ptr;
  logic [CW-1:0]         cnt;
  logic [LOG2_FIFOS-1:0] gnt_idx;
  logic                  gnt_vld;
  logic                  keep;
  logic [LOG2_FIFOS-1:0] sel;
  logic                  hs;
  logic                  credit;
  logic                  inflight;
  logic [LOG2_FIFOS-1:0] infl_sel;
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic [WIDTH-1:0]      buf1_data;
  logic [LOG2_FIFOS-1:0] buf1_fifo;

  // Queue is eligible when enabled and non-empty.
  for (genvar g = 0; g < FIFOS; g++) begin : g_elig
    assign elig[g] = enable[g] &&
                     (fifo_count[count_lsb(g, LOG2_DEPTH) +: LOG2_DEPTH] != '0);
  end

  rr_pick #(.N(FIFOS), .IW(LOG2_FIFOS)) u_pick (
    .req     (elig),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Stay on the current queue while its burst lasts, else rotate.
  assign keep     = elig[ptr] && (cnt < CW'(BURST));
  assign sel      = keep ? ptr : gnt_idx;
  assign hs       = out_valid && out_ready;
  // Buffer slots still free once the in-flight read lands and head leaves.
  assign credit   = (3'(occ) + 3'(inflight) - 3'(hs)) < 3'd2;
  assign fifo_pop = gnt_vld && credit;
  assign fifo_sel = fifo_pop ? sel : '0;

  always_comb begin
    occ_nxt = occ;
    case ({inflight, hs})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Grant pointer and burst counter; any non-pop cycle ends the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (fifo_pop) begin
      ptr <= sel;
      cnt <= keep ? cnt + CW'(1) : CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Read-return tracking: one-cycle RAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      infl_sel <= '0;
    end else begin
      inflight <= fifo_pop;
      infl_sel <= fifo_sel;
    end
  end

  // In-order 2-entry buffer; head lives directly in out_data/out_fifo.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_fifo  <= '0;
      buf1_data <= '0;
      buf1_fifo <= '0;
    end else begin
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != 2'd0);
      busy      <= (occ_nxt != 2'd0) || fifo_pop;
      case ({inflight, hs})
        2'b10: begin
          if (occ == 2'd0) begin
            out_data <= fifo_q;
            out_fifo <= infl_sel;
          end else begin
            buf1_data <= fifo_q;
            buf1_fifo <= infl_sel;
          end
        end
        2'b01: begin
          out_data <= buf1_data;
          out_fifo <= buf1_fifo;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            out_data <= fifo_q;
            out_fifo <= infl_sel;
          end else begin
            out_data  <= buf1_data;
            out_fifo  <= buf1_fifo;
            buf1_data <= fifo_q;
            buf1_fifo <= infl_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linked_list_fifo_pop_scheduler.sv
// Bench for linked_list_fifo_pop_scheduler: a simple array-based FIFO bank
// feeds the DUT; a queue-based model predicts pops and the output stream.
module tb_linked_list_fifo_pop_scheduler;

  localparam int unsigned WIDTH      = 64;
  localparam int unsigned FIFOS      = 4;
  localparam int unsigned LOG2_FIFOS = 2;
  localparam int unsigned LOG2_DEPTH = 11;
  localparam int unsigned BURST      = 4;
  localparam int unsigned DEPTH      = 64;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [FIFOS-1:0]            enable;
  logic [LOG2_DEPTH*FIFOS-1:0] fifo_count;
  logic                        fifo_pop;
  logic [LOG2_FIFOS-1:0]       fifo_sel;
  logic [WIDTH-1:0]            fifo_q;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [LOG2_FIFOS-1:0]       out_fifo;
  logic                        busy;

  linked_list_fifo_pop_scheduler #(
    .WIDTH(WIDTH), .FIFOS(FIFOS), .LOG2_FIFOS(LOG2_FIFOS),
    .LOG2_DEPTH(LOG2_DEPTH), .BURST(BURST)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_count(fifo_count),
    .fifo_pop(fifo_pop), .fifo_sel(fifo_sel), .fifo_q(fifo_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fifo(out_fifo), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO bank environment: per-queue storage with head/tail indices.
  logic [WIDTH-1:0] mem [FIFOS][DEPTH];
  int unsigned hd [FIFOS];
  int unsigned tl [FIFOS];
  int unsigned seq [FIFOS];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < FIFOS; g++) hd[g] <= tl[g];
      fifo_q <= '0;
    end else if (fifo_pop && (tl[fifo_sel] != hd[fifo_sel])) begin
      fifo_q <= mem[fifo_sel][hd[fifo_sel] % DEPTH];
      hd[fifo_sel] <= hd[fifo_sel] + 1;
    end else begin
      fifo_q <= 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  always_comb begin
    fifo_count = '0;
    for (int g = 0; g < FIFOS; g++)
      fifo_count[g*LOG2_DEPTH +: LOG2_DEPTH] = LOG2_DEPTH'(tl[g] - hd[g]);
  end

  int unsigned n_checks;
  int unsigned n_fail;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Behavioural model: expected buffered stream, read in flight, rr state.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [1:0]       q;
  } ent_t;

  ent_t  mbuf[$];
  ent_t  m_inent;
  bit    m_infl;
  int    m_ptr;
  int    m_cnt;

  int          obs_q[$];
  logic [63:0] obs_d[$];
  int          pop_cyc[$];

  always @(negedge clk) begin
    bit e [FIFOS];
    bit rd, cont, anyv, credit, epop;
    int sel;
    if (!rst) begin
      mbuf.delete();
      m_infl = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      chk("rst_fifo_pop", 64'(fifo_pop), 0);
      chk("rst_fifo_sel", 64'(fifo_sel), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_fifo", 64'(out_fifo), 0);
      chk("rst_busy", 64'(busy), 0);
    end else begin
      for (int g = 0; g < FIFOS; g++) e[g] = enable[g] && (tl[g] != hd[g]);
      rd     = (mbuf.size() != 0) && out_ready;
      credit = (int'(mbuf.size()) + int'(m_infl) - int'(rd)) < 2;
      cont   = e[m_ptr] && (m_cnt < BURST);
      anyv   = cont;
      sel    = m_ptr;
      if (!cont) begin
        for (int k = 1; k <= FIFOS; k++) begin
          if (!anyv && e[(m_ptr + k) % FIFOS]) begin
            anyv = 1;
            sel  = (m_ptr + k) % FIFOS;
          end
        end
      end
      epop = anyv && credit;
      chk("fifo_pop", 64'(fifo_pop), 64'(epop));
      chk("fifo_sel", 64'(fifo_sel), epop ? 64'(sel) : 0);
      chk("out_valid", 64'(out_valid), 64'(mbuf.size() != 0));
      chk("busy", 64'(busy), 64'((mbuf.size() != 0) || m_infl));
      if (mbuf.size() != 0) begin
        chk("out_data", out_data, mbuf[0].d);
        chk("out_fifo", 64'(out_fifo), 64'(mbuf[0].q));
      end
      if (fifo_pop) pop_cyc.push_back(int'(cyc));
      if (out_valid && out_ready) begin
        obs_q.push_back(int'(out_fifo));
        obs_d.push_back(out_data);
      end
      if (rd) void'(mbuf.pop_front());
      if (m_infl) mbuf.push_back(m_inent);
      m_infl = epop;
      if (epop) begin
        m_inent.d = mem[sel][hd[sel] % DEPTH];
        m_inent.q = 2'(sel);
        m_cnt     = cont ? m_cnt + 1 : 1;
        m_ptr     = sel;
      end else begin
        m_cnt = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int q, input int n);
    for (int i = 0; i < n; i++) begin
      mem[q][tl[q] % DEPTH] = {32'(q), 32'(seq[q])};
      seq[q]++;
      tl[q]++;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_d.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int b;
    b = 0;
    while (obs_q.size() < n && b < budget) begin
      step(1);
      b++;
    end
    chk(nm, 64'(obs_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input string nm);
    int b;
    b = 0;
    while (busy && b < 20) begin
      step(1);
      b++;
    end
    chk(nm, 64'(busy), 0);
  endtask

  initial begin
    int e1 [13];
    int e5 [6];
    int pushc, vc, b;
    e1 = '{0, 0, 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0};
    e5 = '{0, 0, 1, 1, 3, 3};
    enable    = '1;
    out_ready = 1'b0;
    rst       = 1'b0;
    step(3);
    chk("lit_rst_valid", 64'(out_valid), 0);
    chk("lit_rst_busy", 64'(busy), 0);
    rst = 1'b1;

    // Burst-limited round robin between Q0 and Q2.
    clear_obs();
    push(0, 10);
    push(2, 3);
    out_ready = 1'b1;
    wait_out(13, 60, "t1_count");
    for (int i = 0; i < 13; i++)
      if (i < obs_q.size()) chk($sformatf("t1_order%0d", i), 64'(obs_q[i]), 64'(e1[i]));
    if (obs_d.size() == 13) begin
      chk("t1_data4", obs_d[4], 64'h0000_0002_0000_0000);
      chk("t1_data12", obs_d[12], 64'h0000_0000_0000_0009);
    end
    wait_idle("t1_idle");

    // Single busy queue keeps popping back to back past the burst limit.
    clear_obs();
    push(3, 5);
    wait_out(5, 40, "t2_count");
    for (int i = 0; i < 5; i++)
      if (i < obs_q.size()) begin
        chk($sformatf("t2_fifo%0d", i), 64'(obs_q[i]), 3);
        chk($sformatf("t2_data%0d", i), obs_d[i], {32'd3, 32'(i)});
      end
    chk("t2_pops", 64'(pop_cyc.size()), 5);
    if (pop_cyc.size() == 5) chk("t2_b2b", 64'(pop_cyc[4] - pop_cyc[0]), 4);
    wait_idle("t2_idle");

    // Backpressure: two pops fill the buffer, then the rest stream out.
    clear_obs();
    out_ready = 1'b0;
    push(1, 8);
    step(6);
    chk("t3_pops_held", 64'(pop_cyc.size()), 2);
    chk("t3_valid_held", 64'(out_valid), 1);
    chk("t3_data_held", out_data, 64'h0000_0001_0000_0000);
    out_ready = 1'b1;
    wait_out(8, 40, "t3_count");
    for (int i = 0; i < 8; i++)
      if (i < obs_d.size()) chk($sformatf("t3_data%0d", i), obs_d[i], {32'd1, 32'(i)});
    wait_idle("t3_idle");

    // Reset while the buffer holds two entries.
    push(0, 6);
    step(3);
    out_ready = 1'b0;
    step(1);
    chk("t4_busy_pre", 64'(busy), 1);
    chk("t4_valid_pre", 64'(out_valid), 1);
    rst = 1'b0;
    #1;
    chk("t4_valid_async", 64'(out_valid), 0);
    chk("t4_busy_async", 64'(busy), 0);
    chk("t4_data_async", out_data, 0);
    step(1);
    chk("t4_pop_rst", 64'(fifo_pop), 0);
    chk("t4_fifo_rst", 64'(out_fifo), 0);
    rst = 1'b1;
    out_ready = 1'b1;

    // Masked queue is never served; rotation skips it.
    clear_obs();
    enable = 4'b1011;
    for (int g = 0; g < FIFOS; g++) push(g, 2);
    wait_out(6, 40, "t5_count");
    for (int i = 0; i < 6; i++)
      if (i < obs_q.size()) chk($sformatf("t5_order%0d", i), 64'(obs_q[i]), 64'(e5[i]));
    wait_idle("t5_idle");
    chk("t5_q2_count", 64'(fifo_count[2*LOG2_DEPTH +: LOG2_DEPTH]), 2);

    // Latency from count visible to pop to output valid.
    clear_obs();
    pushc = int'(cyc);
    push(1, 1);
    b = 0;
    while (!out_valid && b < 10) begin
      step(1);
      b++;
    end
    vc = int'(cyc);
    chk("t6_valid_seen", 64'(out_valid), 1);
    chk("t6_pops", 64'(pop_cyc.size()), 1);
    if (pop_cyc.size() == 1) begin
      chk("t6_pop_lat", 64'(pop_cyc[0] - pushc), 0);
      chk("t6_valid_lat", 64'(vc - pop_cyc[0]), 2);
    end
    wait_idle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
